// File: rtl/mux8_pkg.sv
// Shared types and constants for the round-robin 8:1 mux scheduler.
// Imported by the pick logic and the scheduler top.
package mux8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OUT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(
        input logic [SEL_W-1:0] i
    );
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from 7 back to 0.
module rr_pick8
    import mux8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] pos;

    assign any = |req;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // 3-bit add wraps the search naturally
            pos = ptr + SEL_W'(k);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving one shared 8:1 mux, sampling its
// true/complement pair and streaming the bit out with a winner ack.
module mux8_rr_sched
    import mux8_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             flush,
    input  logic             mux_out,
    input  logic             mux_out_n,
    output logic [SEL_W-1:0] sel,
    output logic             en_n,
    output logic [N_REQ-1:0] ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [SEL_W-1:0] out_id,
    output logic             err
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("SETTLE_CYC must be in 1..15");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             valid_q, valid_d;
    logic             data_q, data_d;
    logic [SEL_W-1:0] id_q, id_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        en_n_d  = en_n_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        if (flush) begin
            // abort: drop the result, keep ptr and err as they are
            state_d = IDLE;
            en_n_d  = 1'b1;
            valid_d = 1'b0;
            ack_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        en_n_d  = 1'b0;
                        cnt_d   = CNT_W'(SETTLE_CYC);
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        data_d  = mux_out;
                        id_d    = sel_q;
                        valid_d = 1'b1;
                        ack_d   = onehot(sel_q);
                        en_n_d  = 1'b1;
                        err_d   = err_q | (mux_out == mux_out_n);
                        state_d = OUT;
                    end
                end
                OUT: begin
                    ack_d = '0;
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        ptr_d   = sel_q + SEL_W'(1);
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            en_n_q  <= 1'b1;
            ack_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign sel       = sel_q;
    assign en_n      = en_n_q;
    assign ack       = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed table, corner sequences, and a
// random run against a transaction-phase reference model.
module tb_mux8_rr_sched;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       flush = 1'b0;
    logic       mux_out = 1'b0;
    logic       mux_out_n = 1'b1;
    logic       out_ready = 1'b0;
    logic [2:0] sel;
    logic       en_n;
    logic [7:0] ack;
    logic       out_valid;
    logic       out_data;
    logic [2:0] out_id;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux8_rr_sched #(.SETTLE_CYC(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flush     (flush),
        .mux_out   (mux_out),
        .mux_out_n (mux_out_n),
        .sel       (sel),
        .en_n      (en_n),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .err       (err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] req;
        logic       mo;
        logic       mon;
        logic       rdy;
        logic [2:0] sel;
        logic       en_n;
        logic [7:0] ack;
        logic       v;
        logic       d;
        logic [2:0] id;
    } vec_t;

    vec_t tbl [14];

    // reference model: phase = cycles since grant (0 = idle)
    int         m_ph;
    int         m_ptr;
    int         m_sel;
    int         m_id;
    logic       m_en_n, m_v, m_d, m_err;
    logic [7:0] m_ack;

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_ptr = 0; m_sel = 0; m_id = 0;
        m_en_n = 1'b1; m_v = 1'b0; m_d = 1'b0;
        m_err = 1'b0; m_ack = '0;
    endtask

    task automatic model_step();
        if (flush) begin
            m_ph = 0; m_en_n = 1'b1; m_v = 1'b0; m_ack = '0;
        end else if (m_ph == 0) begin
            if (req != 0) begin
                m_sel = rr_pick(req, m_ptr);
                m_en_n = 1'b0;
                m_ph = 1;
            end
        end else if (m_ph < S) begin
            m_ph++;
        end else if (m_ph == S) begin
            m_d = mux_out;
            m_id = m_sel;
            m_v = 1'b1;
            m_ack = 8'(1 << m_sel);
            m_en_n = 1'b1;
            m_err = m_err | (mux_out == mux_out_n);
            m_ph = S + 1;
        end else begin
            m_ack = '0;
            if (out_ready) begin
                m_v = 1'b0;
                m_ptr = (m_sel + 1) % 8;
                m_ph = 0;
            end
        end
    endtask

    task automatic wait_valid(input string nm, input int lim);
        int c = 0;
        while (!out_valid && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk(nm, int'(out_valid), 1);
    endtask

    initial begin
        tbl[0]  = {8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[1]  = {8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[2]  = {8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 8'h20, 1'b1, 1'b1, 3'd5};
        tbl[3]  = {8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 8'h00, 1'b1, 1'b1, 3'd5};
        tbl[4]  = {8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 1'b1, 3'd5};
        tbl[5]  = {8'h41, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5};
        tbl[6]  = {8'h41, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5};
        tbl[7]  = {8'h41, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1, 8'h40, 1'b1, 1'b0, 3'd6};
        tbl[8]  = {8'h41, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 8'h00, 1'b0, 1'b0, 3'd6};
        tbl[9]  = {8'h41, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd6};
        tbl[10] = {8'h41, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd6};
        tbl[11] = {8'h41, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1, 3'd0};
        tbl[12] = {8'h41, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0};
        tbl[13] = {8'h41, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};

        // reset values
        @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_en_n", int'(en_n), 1);
        chk("rst_ack", int'(ack), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_id", int'(out_id), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        // directed table: single grant, wrap-around, ptr skipping
        for (int k = 0; k < 14; k++) begin
            req = tbl[k].req;
            mux_out = tbl[k].mo;
            mux_out_n = tbl[k].mon;
            out_ready = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_sel", k), int'(sel), int'(tbl[k].sel));
            chk($sformatf("tbl%0d_en_n", k), int'(en_n), int'(tbl[k].en_n));
            chk($sformatf("tbl%0d_ack", k), int'(ack), int'(tbl[k].ack));
            chk($sformatf("tbl%0d_valid", k), int'(out_valid), int'(tbl[k].v));
            chk($sformatf("tbl%0d_data", k), int'(out_data), int'(tbl[k].d));
            chk($sformatf("tbl%0d_id", k), int'(out_id), int'(tbl[k].id));
            chk($sformatf("tbl%0d_err", k), int'(err), 0);
        end

        // reset asserted mid-SETTLE takes effect immediately
        rst = 1'b1;
        #1;
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_en_n", int'(en_n), 1);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_err", int'(err), 0);
        @(negedge clk);
        chk("midrst_hold_valid", int'(out_valid), 0);
        req = 8'hFF;
        out_ready = 1'b1;
        rst = 1'b0;

        // all requesting: strict rotation, one result every S+2 cycles
        begin
            int got = 0;
            int cyc = 0;
            int last = 0;
            while (got < 9 && cyc < 60) begin
                @(negedge clk);
                cyc++;
                mux_out = 1'($urandom_range(0, 1));
                mux_out_n = ~mux_out;
                if (out_valid) begin
                    chk($sformatf("rot%0d_id", got), int'(out_id), got % 8);
                    if (got > 0) chk($sformatf("rot%0d_period", got), cyc - last, S + 2);
                    else chk("rot0_latency", cyc, S + 1);
                    last = cyc;
                    got++;
                    if (got == 9) req = '0;
                end
            end
            chk("rot_count", got, 9);
        end
        @(negedge clk);
        out_ready = 1'b0;

        // backpressure: result held, no new grant
        req = 8'h08;
        mux_out = 1'b1;
        mux_out_n = 1'b0;
        wait_valid("bp_valid", 10);
        chk("bp_first_id", int'(out_id), 3);
        req = 8'hFF;
        mux_out = 1'b0;
        mux_out_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), int'(out_valid), 1);
            chk($sformatf("bp%0d_data", k), int'(out_data), 1);
            chk($sformatf("bp%0d_id", k), int'(out_id), 3);
            chk($sformatf("bp%0d_en_n", k), int'(en_n), 1);
            chk($sformatf("bp%0d_sel", k), int'(sel), 3);
        end
        out_ready = 1'b1;
        req = '0;
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        out_ready = 1'b0;

        // flush during SETTLE aborts with no ack or result
        req = 8'h02;
        begin
            int c = 0;
            while (en_n && c < 10) begin
                @(negedge clk);
                c++;
            end
            chk("fl_grant", int'(en_n), 0);
        end
        chk("fl_sel", int'(sel), 1);
        flush = 1'b1;
        req = '0;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_en_n", int'(en_n), 1);
        chk("fl_valid", int'(out_valid), 0);
        chk("fl_ack", int'(ack), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("fl_quiet%0d", k), int'(out_valid) + int'(ack != 0), 0);
        end

        // equal mux pair sets sticky err; ptr still 4 so req 0 wins
        req = 8'h01;
        mux_out = 1'b1;
        mux_out_n = 1'b1;
        out_ready = 1'b1;
        wait_valid("err_valid", 10);
        chk("err_id", int'(out_id), 0);
        chk("err_set", int'(err), 1);
        req = '0;
        mux_out_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("err_sticky%0d", k), int'(err), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("err_cleared", int'(err), 0);
        out_ready = 1'b0;
        rst = 1'b0;

        // random run against the reference model
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 7) == 0) req = 8'($urandom_range(0, 255));
            mux_out = 1'($urandom_range(0, 1));
            mux_out_n = ($urandom_range(0, 15) == 0) ? mux_out : ~mux_out;
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("rnd_sel", int'(sel), m_sel);
            chk("rnd_en_n", int'(en_n), int'(m_en_n));
            chk("rnd_ack", int'(ack), int'(m_ack));
            chk("rnd_valid", int'(out_valid), int'(m_v));
            chk("rnd_data", int'(out_data), int'(m_d));
            chk("rnd_id", int'(out_id), m_id);
            chk("rnd_err", int'(err), int'(m_err));
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
